// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// State encoding, bus widths and address decode helpers.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [29:0] word_index(
    input logic [31:0] addr
  );
    return addr[31:2];
  endfunction

  function automatic logic in_range(
    input logic [29:0] idx,
    input int          depth
  );
    return $signed({2'b00, idx}) < depth;
  endfunction

endpackage

// File: rtl/dmem_storage.sv
// Word-wide storage array with byte-enable writes.
// Synchronous read port; the read register holds until the next read.
module dmem_storage
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = (DEPTH_WORDS > 1) ?
                      $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder with request/response handshakes.
// One request outstanding; access happens on the edge entering RESP.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ?
                      $clog2(DEPTH_WORDS) : 1;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              err_q, err_d;

  logic              accept;
  logic              go_resp;
  logic              in_idle;
  logic              acc_write;
  logic              acc_err;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic [29:0]       acc_idx;
  logic [WORD_W-1:0] rd;

  assign in_idle   = (state_q == IDLE);
  assign req_ready = rst_n && in_idle;
  assign accept    = req_valid && req_ready;

  // With zero wait the access uses the live request, else the latched one.
  assign acc_write = in_idle ? req_write : write_q;
  assign acc_addr  = in_idle ? req_addr  : addr_q;
  assign acc_wdata = in_idle ? req_wdata : wdata_q;
  assign acc_be    = in_idle ? req_be    : be_q;
  assign acc_idx   = word_index(acc_addr);
  assign acc_err   = (acc_addr[1:0] != 2'b00) ||
                     !in_range(acc_idx, DEPTH_WORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    go_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
            err_d   = acc_err;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          go_resp = 1'b1;
          err_d   = acc_err;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  dmem_storage #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_storage (
    .clk_i  (clk),
    .we_i   (go_resp && acc_write && !acc_err),
    .re_i   (go_resp && !acc_write && !acc_err),
    .addr_i (acc_idx[AW-1:0]),
    .be_i   (acc_be),
    .wdata_i(acc_wdata),
    .rdata_o(rd)
  );

  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !write_q) ?
                      rd : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// Covers a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_resp_rdata;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(2)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  data_mem_responder #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(0)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_write (b_req_write),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .req_be    (b_req_be),
    .resp_valid(b_resp_valid),
    .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata),
    .resp_err  (b_resp_err)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  vec_t va [16];
  vec_t vb [7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Edges counted from the accept edge (inclusive) to resp_valid.
  task automatic txn(input logic w,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [3:0] be,
                     output logic [31:0] rd,
                     output logic er,
                     output int lat);
    int n;
    n = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = wd;
    req_be     = be;
    resp_ready = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'hF;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    va[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    va[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    va[2]  = '{1'b1, 32'h10,  32'h0000AAAA, 4'h3, 32'h0,        1'b0};
    va[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADAAAA, 1'b0};
    va[4]  = '{1'b1, 32'h0C,  32'h01020304, 4'hF, 32'h0,        1'b0};
    va[5]  = '{1'b0, 32'h13,  32'h0,        4'h0, 32'h0,        1'b1};
    va[6]  = '{1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1};
    va[7]  = '{1'b1, 32'h402, 32'h12345678, 4'hF, 32'h0,        1'b1};
    va[8]  = '{1'b1, 32'h0E,  32'hCAFEF00D, 4'hF, 32'h0,        1'b1};
    va[9]  = '{1'b0, 32'h0C,  32'h0,        4'h0, 32'h01020304, 1'b0};
    va[10] = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    va[11] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADAAAA, 1'b0};
    va[12] = '{1'b1, 32'h10,  32'h00770000, 4'h4, 32'h0,        1'b0};
    va[13] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE77AAAA, 1'b0};
    va[14] = '{1'b1, 32'h20,  32'h11111111, 4'hF, 32'h0,        1'b0};
    va[15] = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11111111, 1'b0};

    vb[0] = '{1'b1, 32'h0,   32'hAAAA0000, 4'hF, 32'h0,        1'b0};
    vb[1] = '{1'b1, 32'h4,   32'h0000BBBB, 4'hF, 32'h0,        1'b0};
    vb[2] = '{1'b0, 32'h0,   32'h0,        4'h0, 32'hAAAA0000, 1'b0};
    vb[3] = '{1'b0, 32'h4,   32'h0,        4'h0, 32'h0000BBBB, 1'b0};
    vb[4] = '{1'b0, 32'h401, 32'h0,        4'h0, 32'h0,        1'b1};
    vb[5] = '{1'b1, 32'h0,   32'h11000000, 4'h8, 32'h0,        1'b0};
    vb[6] = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h11AA0000, 1'b0};

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0;
    b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    b_resp_ready = 1'b0;

    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_b_req_ready", 32'(b_req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      txn(va[i].w, va[i].a, va[i].wd, va[i].be, rd, er, lat);
      chk($sformatf("v%0d_rdata", i), rd, va[i].erd);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(va[i].eerr));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_done", i), 32'(resp_valid), 32'd0);
      chk($sformatf("v%0d_clr", i), resp_rdata, 32'h0);
    end

    // Stalled response while request inputs churn.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0;
    req_addr = 32'h10; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_arrive", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'($urandom);
      req_addr  = {$urandom_range(0, 255), 2'b00};
      req_wdata = $urandom;
      req_be    = 4'hF;
      chk($sformatf("hold%0d_valid", i), 32'(resp_valid), 32'd1);
      chk($sformatf("hold%0d_rdata", i), resp_rdata, 32'hDE77AAAA);
      chk($sformatf("hold%0d_err", i), 32'(resp_err), 32'd0);
      chk($sformatf("hold%0d_ready", i), 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_valid", 32'(resp_valid), 32'd0);
    chk("hold_release_rdata", resp_rdata, 32'h0);
    @(posedge clk);
    #1;
    chk("hold_single_resp", 32'(resp_valid), 32'd0);
    chk("hold_idle_ready", 32'(req_ready), 32'd1);

    // Reset in the middle of a store's wait.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1;
    req_addr = 32'h20; req_wdata = 32'h22222222; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_rdata", resp_rdata, 32'h0);
    chk("mid_rst_err", 32'(resp_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_valid_hold", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("post_rst_rdata", rd, 32'h11111111);
    chk("post_rst_err", 32'(er), 32'd0);

    // Zero-wait instance under continuous traffic.
    @(negedge clk);
    b_req_valid  = 1'b1;
    b_resp_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      if (k % 2 == 0) begin
        b_req_write = vb[k/2].w;
        b_req_addr  = vb[k/2].a;
        b_req_wdata = vb[k/2].wd;
        b_req_be    = vb[k/2].be;
        chk($sformatf("b%0d_ready", k), 32'(b_req_ready), 32'd1);
        chk($sformatf("b%0d_idle", k), 32'(b_resp_valid), 32'd0);
      end else begin
        chk($sformatf("b%0d_valid", k), 32'(b_resp_valid), 32'd1);
        chk($sformatf("b%0d_busy", k), 32'(b_req_ready), 32'd0);
        chk($sformatf("b%0d_rdata", k), b_resp_rdata, vb[k/2].erd);
        chk($sformatf("b%0d_err", k), 32'(b_resp_err),
            32'(vb[k/2].eerr));
        b_req_write = ~b_req_write;
        b_req_addr  = $urandom;
        b_req_wdata = $urandom;
        b_req_be    = 4'hF;
      end
    end
    @(negedge clk);
    b_req_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
